// File: rtl/store_narrow_buffer_pkg.sv
// Shared definitions for the store narrowing buffer: store op encodings,
// byte-enable patterns and the layout of one buffered store entry.
// Optional feature macro: STORE_MERGE_EN (see store_narrow_buffer.sv).
package store_narrow_buffer_pkg;

  // Store width encodings presented on in_op
  localparam logic [1:0] STORE_SW  = 2'b00;
  localparam logic [1:0] STORE_SH  = 2'b01;
  localparam logic [1:0] STORE_SB  = 2'b10;
  localparam logic [1:0] STORE_RSV = 2'b11;

  // Byte-enable patterns for word and halfword stores
  localparam logic [3:0] BE_WORD = 4'b1111;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;

  // One buffered store: word address (bits 31:2), lane-positioned data and enables
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

endpackage

// File: rtl/store_narrow_buffer_lane_pack.sv
// store_lane_pack: combinational narrowing of LSB-justified register data
// into memory lane positions with byte enables, plus misalignment detection.
// A reserved op is reported as misaligned so the caller drops it.
module store_lane_pack
  import store_narrow_buffer_pkg::*;
(
  input  logic [1:0]  i_op,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_data,
  output logic [3:0]  o_be,
  output logic        o_misalign
);

  // Place the store bytes into their lanes and flag illegal alignment
  always_comb begin
    o_data     = 32'h0;
    o_be       = 4'b0000;
    o_misalign = 1'b0;
    case (i_op)
      STORE_SW: begin
        o_data     = i_wdata;
        o_be       = BE_WORD;
        o_misalign = (i_addr_lo != 2'b00);
      end
      STORE_SH: begin
        o_misalign = i_addr_lo[0];
        if (i_addr_lo[1]) begin
          o_data = {i_wdata[15:0], 16'h0000};
          o_be   = BE_HI;
        end else begin
          o_data = {16'h0000, i_wdata[15:0]};
          o_be   = BE_LO;
        end
      end
      STORE_SB: begin
        o_data = {24'h000000, i_wdata[7:0]} << {i_addr_lo, 3'b000};
        o_be   = 4'b0001 << i_addr_lo;
      end
      default: begin
        o_misalign = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_buffer.sv
// store_narrow_buffer: narrows CPU stores to byte/half/word lanes and queues
// them in a DEPTH-entry FIFO that drains to data memory.
// Optional feature macro: STORE_MERGE_EN -- an aligned store hitting the same
// word as the (not-being-popped) tail entry is merged into it instead of
// allocating a new entry.
//
// Handshakes: both sides use valid/ready. A transfer happens on the rising
// edge where valid && ready are both high; valid must not depend on ready.
// in_ready and out_valid are derived from the occupancy count only, so a full
// buffer refuses input even in a cycle where the head is being popped.
module store_narrow_buffer
  import store_narrow_buffer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_addr,
  input  logic [31:0]      in_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_addr,
  output logic [31:0]      out_data,
  output logic [3:0]       out_be,
  output logic             align_err,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = CNT_W - 1;

  sb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_align_err;

  logic [31:0]      w_pack_data;
  logic [3:0]       w_pack_be;
  logic             w_misalign;
  logic             w_accept;
  logic             w_pop;
  logic             w_enq;
  logic             w_alloc;
  sb_entry_t        w_head;

  store_lane_pack u_pack (
    .i_op       (in_op),
    .i_addr_lo  (in_addr[1:0]),
    .i_wdata    (in_wdata),
    .o_data     (w_pack_data),
    .o_be       (w_pack_be),
    .o_misalign (w_misalign)
  );

  assign in_ready  = (r_count != CNT_W'(DEPTH));
  assign out_valid = (r_count != '0);
  assign w_accept  = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  // Rejected stores still complete the handshake but never touch the FIFO
  assign w_enq     = w_accept && !w_misalign;

`ifdef STORE_MERGE_EN
  logic [PTR_W-1:0] w_tail_ptr;
  logic             w_merge;

  assign w_tail_ptr = r_wr_ptr - 1'b1;
  // With one entry the tail is the head, so it may not merge while leaving
  assign w_merge    = w_enq && (r_count != '0) &&
                      (r_mem[w_tail_ptr].waddr == in_addr[31:2]) &&
                      !(w_pop && (r_count == CNT_W'(1)));
  assign w_alloc    = w_enq && !w_merge;
`else
  assign w_alloc    = w_enq;
`endif

  // Entry storage: allocate at the write pointer or merge into the tail
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_mem[r_wr_ptr].waddr <= in_addr[31:2];
      r_mem[r_wr_ptr].data  <= w_pack_data;
      r_mem[r_wr_ptr].be    <= w_pack_be;
    end
`ifdef STORE_MERGE_EN
    else if (w_merge) begin
      for (int i = 0; i < 4; i++) begin
        if (w_pack_be[i]) begin
          r_mem[w_tail_ptr].data[8*i +: 8] <= w_pack_data[8*i +: 8];
        end
      end
      r_mem[w_tail_ptr].be <= r_mem[w_tail_ptr].be | w_pack_be;
    end
`endif
  end

  // Pointers, occupancy and the one-cycle reject pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_align_err <= 1'b0;
    end else begin
      if (w_alloc) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_alloc, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_align_err <= w_accept && w_misalign;
    end
  end

  // Outputs come straight from the head entry; stale content when empty
  assign w_head    = r_mem[r_rd_ptr];
  assign out_addr  = {w_head.waddr, 2'b00};
  assign out_data  = w_head.data;
  assign out_be    = w_head.be;
  assign align_err = r_align_err;
  assign count     = r_count;

endmodule

// File: tb/tb_store_narrow_buffer.sv
// Testbench for store_narrow_buffer: scenario tasks with a scoreboard queue
// of expected {addr, data, be} entries compared as the DUT drains.
// Honours STORE_MERGE_EN in its reference model when the macro is defined.
module tb_store_narrow_buffer;
  import store_narrow_buffer_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_addr;
  logic [31:0]      in_wdata;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_addr;
  logic [31:0]      out_data;
  logic [3:0]       out_be;
  logic             align_err;
  logic [CNT_W-1:0] count;

  logic [67:0] exp_q[$];
  int n_tests;
  int n_fail;

  store_narrow_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_addr   (in_addr),
    .in_wdata  (in_wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .out_be    (out_be),
    .align_err (align_err),
    .count     (count)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  function automatic logic model_ok(input logic [1:0] op, input logic [31:0] a);
    case (op)
      2'b00:   return a[1:0] == 2'b00;
      2'b01:   return a[0] == 1'b0;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [67:0] model_entry(input logic [1:0] op, input logic [31:0] a,
                                              input logic [31:0] d);
    logic [31:0] data;
    logic [3:0]  be;
    data = 32'h0;
    be   = 4'b0;
    if (op == 2'b00) begin
      data = d;
      be   = 4'b1111;
    end else if (op == 2'b01) begin
      if (a[1]) begin data = {d[15:0], 16'h0}; be = 4'b1100; end
      else      begin data = {16'h0, d[15:0]}; be = 4'b0011; end
    end else begin
      case (a[1:0])
        2'd0: begin data = {24'h0, d[7:0]};        be = 4'b0001; end
        2'd1: begin data = {16'h0, d[7:0], 8'h0};  be = 4'b0010; end
        2'd2: begin data = {8'h0, d[7:0], 16'h0};  be = 4'b0100; end
        default: begin data = {d[7:0], 24'h0};     be = 4'b1000; end
      endcase
    end
    return {a[31:2], 2'b00, data, be};
  endfunction

  // ---------------- driver + scoreboard ----------------
  // Drive one cycle of inputs, score the pop and record the push that
  // the next rising edge will perform, then return to idle inputs.
  task automatic drive_cycle(input logic v, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] d, input logic ordy);
    logic [67:0] e;
    logic [67:0] t;
    in_valid  = v;
    in_op     = op;
    in_addr   = a;
    in_wdata  = d;
    out_ready = ordy;
    @(negedge clk);
    if (out_valid && out_ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: got %h expected no output", {out_addr, out_data, out_be});
      end else begin
        e = exp_q.pop_front();
        if ({out_addr, out_data, out_be} !== e) begin
          n_fail++;
          $display("FAIL sb_head: got %h expected %h", {out_addr, out_data, out_be}, e);
        end
      end
    end
    if (in_valid && in_ready && model_ok(op, a)) begin
      e = model_entry(op, a, d);
`ifdef STORE_MERGE_EN
      if (exp_q.size() != 0 && exp_q[exp_q.size()-1][67:36] == e[67:36]) begin
        t = exp_q[exp_q.size()-1];
        for (int i = 0; i < 4; i++) begin
          if (e[i]) t[4 + 8*i +: 8] = e[4 + 8*i +: 8];
        end
        t[3:0] = t[3:0] | e[3:0];
        exp_q[exp_q.size()-1] = t;
      end else begin
        exp_q.push_back(e);
      end
`else
      t = e;
      exp_q.push_back(t);
`endif
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while (exp_q.size() != 0 && budget > 0) begin
      drive_cycle(1'b0, STORE_SW, 32'h0, 32'h0, 1'b1);
      budget--;
    end
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d left expected 0", exp_q.size());
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || count !== '0) begin
      n_fail++;
      $display("FAIL drain_empty: got valid=%b count=%0d expected valid=0 count=0",
               out_valid, count);
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({count, out_valid, in_ready, align_err} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got count=%0d ov=%b ir=%b ae=%b expected 0 0 1 0",
               count, out_valid, in_ready, align_err);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_sb();
    drive_cycle(1'b1, STORE_SB, 32'h0000_1003, 32'h0000_00A5, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b1 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL sb_valid: got ov=%b count=%0d expected 1 1", out_valid, count);
    end
    n_tests++;
    if ({out_addr, out_data, out_be} !== {32'h0000_1000, 32'hA500_0000, 4'b1000}) begin
      n_fail++;
      $display("FAIL sb_lane: got %h %h %b expected 00001000 a5000000 1000",
               out_addr, out_data, out_be);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_align();
    drive_cycle(1'b1, STORE_SH, 32'h0000_2002, 32'h1234_BEEF, 1'b0);
    @(negedge clk);
    n_tests++;
    if (out_data !== 32'hBEEF_0000 || out_be !== 4'b1100 || align_err !== 1'b0) begin
      n_fail++;
      $display("FAIL sh_hi: got %h %b ae=%b expected beef0000 1100 0", out_data, out_be, align_err);
    end
    @(posedge clk);
    #1;
    drive_cycle(1'b1, STORE_SH, 32'h0000_2001, 32'h1234_BEEF, 1'b0);
    @(negedge clk);
    n_tests++;
    if (align_err !== 1'b1 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL sh_misalign: got ae=%b count=%0d expected 1 1", align_err, count);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    n_tests++;
    if (align_err !== 1'b0) begin
      n_fail++;
      $display("FAIL align_pulse: got ae=%b expected 0", align_err);
    end
    @(posedge clk);
    #1;
    drive_cycle(1'b1, STORE_SW, 32'h0000_2006, 32'hCAFE_F00D, 1'b0);
    @(negedge clk);
    n_tests++;
    if (align_err !== 1'b1 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL sw_misalign: got ae=%b count=%0d expected 1 1", align_err, count);
    end
    @(posedge clk);
    #1;
    drive_cycle(1'b1, STORE_RSV, 32'h0000_2004, 32'h1111_2222, 1'b0);
    @(negedge clk);
    n_tests++;
    if (align_err !== 1'b1 || count !== 3'd1) begin
      n_fail++;
      $display("FAIL rsv_op: got ae=%b count=%0d expected 1 1", align_err, count);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_full_and_wrap();
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, STORE_SW, 32'h10 + 32'(4*i), $urandom, 1'b0);
    end
    @(negedge clk);
    n_tests++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full: got count=%0d ir=%b expected 4 0", count, in_ready);
    end
    @(posedge clk);
    #1;
    drive_cycle(1'b1, STORE_SW, 32'h20, 32'hDEAD_0001, 1'b0);
    drive_cycle(1'b1, STORE_SW, 32'h20, 32'hDEAD_0002, 1'b1);
    @(negedge clk);
    n_tests++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL full_no_pass: got count=%0d expected 3", count);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, STORE_SW, 32'h40 + 32'(4*i), $urandom, 1'b1);
    end
    @(negedge clk);
    n_tests++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL push_pop: got count=%0d expected 3", count);
    end
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, STORE_SW, 32'h80 + 32'(4*i), $urandom, 1'b0);
    end
    @(negedge clk);
    n_tests++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL pre_reset: got count=%0d expected 3", count);
    end
    @(posedge clk);
    #1;
    // A misaligned request alongside reset must not raise align_err
    reset    = 1'b1;
    in_valid = 1'b1;
    in_op    = STORE_SH;
    in_addr  = 32'h0000_0091;
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    n_tests++;
    if ({count, out_valid, in_ready, align_err} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got count=%0d ov=%b ir=%b ae=%b expected 0 0 1 0",
               count, out_valid, in_ready, align_err);
    end
    @(posedge clk);
    #1;
    drive_cycle(1'b1, STORE_SW, 32'h0000_00C0, 32'h5A5A_A5A5, 1'b0);
    drain();
  endtask

  task automatic test_merge();
    drive_cycle(1'b1, STORE_SB, 32'h0000_3000, 32'h0000_0011, 1'b0);
    drive_cycle(1'b1, STORE_SB, 32'h0000_3001, 32'h0000_0022, 1'b0);
    @(negedge clk);
    n_tests++;
`ifdef STORE_MERGE_EN
    if (count !== 3'd1 || out_be !== 4'b0011 || out_data !== 32'h0000_2211) begin
      n_fail++;
      $display("FAIL merge: got count=%0d be=%b data=%h expected 1 0011 00002211",
               count, out_be, out_data);
    end
`else
    if (count !== 3'd2 || out_be !== 4'b0001 || out_data !== 32'h0000_0011) begin
      n_fail++;
      $display("FAIL no_merge: got count=%0d be=%b data=%h expected 2 0001 00000011",
               count, out_be, out_data);
    end
`endif
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a;
    for (int i = 0; i < 60; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = 32'h0000_5000 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      drive_cycle(1'($urandom_range(0, 1)), op, a, $urandom, 1'($urandom_range(0, 1)));
    end
    drain();
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_op     = STORE_SW;
    in_addr   = 32'h0;
    in_wdata  = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_sb();
    test_align();
    test_full_and_wrap();
    test_reset_mid();
    test_merge();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/store_narrow_buffer.md
Name: store_narrow_buffer

Overview:
- Store-side counterpart of the immediate/load extender: narrows 32-bit register data to byte/halfword/word lanes with byte enables.
- Queues the narrowed stores in a small FIFO and drains them to data memory over a valid/ready handshake.
- Sits between the MEM-stage store path and the DM write port.
- Decouples CPU store issue from memory write acceptance.

Parameters:
- DEPTH, 4, number of buffered stores (power of two, ≥2)
- CNT_W, 3, width of occupancy count (log2(DEPTH)+1)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  store request present
- in_ready  out  1  buffer can accept; = (count != DEPTH)
- in_op  in  2  store width: SW/SH/SB
- in_addr  in  32  byte address
- in_wdata  in  32  register (rt) data, LSB-justified
- out_valid  out  1  head entry present; = (count != 0)
- out_ready  in  1  memory accepts head
- out_addr  out  32  word-aligned address, {addr[31:2],2'b00}
- out_data  out  32  lane-positioned data
- out_be  out  4  byte enables
- align_err  out  1  one-cycle pulse for a rejected store
- count  out  CNT_W  current occupancy

Behaviour:
- Accept happens when in_valid && in_ready, at the rising edge. Pop happens when out_valid && out_ready, at the rising edge.
- Latency: a store accepted at edge N appears on out_* after edge N (zero-bubble), provided the buffer was empty.
- Narrowing, done in the accept cycle:
  - SB: byte k = addr[1:0]; data lane k = wdata[7:0]; be = 1<<k; other lanes 0.
  - SH: half h = addr[1]; lanes = wdata[15:0]; be = h ? 4'b1100 : 4'b0011.
  - SW: data = wdata; be = 4'b1111.
- Misalignment (SH with addr[0]=1, SW with addr[1:0]!=0) or the reserved op 2'b11:
  - handshake completes (in_ready honored), nothing is enqueued;
  - align_err=1 for exactly the next cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance. When full, in_ready=0 even if a pop occurs that cycle (no pass-through).
- Empty: out_valid=0, and out_addr/out_data/out_be hold the last head value (don't-care).
- Pointers wrap modulo DEPTH.
- Ordering is strict FIFO.
- Reset, including mid-operation: pointers=0, count=0, align_err=0, all pending entries dropped. In the cycle after reset, out_valid=0 and in_ready=1. Entry storage is not cleared.
- out_* are driven directly from the head register (no combinational path from in_*), except in_ready/out_valid, which are derived from count.

Optional Feature:
- Macro: STORE_MERGE_EN.
- Defined:
  - Merge condition: an accepted aligned store merges into the tail entry when count>0, tail word address equals the new word address, and the tail is not being popped this cycle. DEPTH≥2 guarantees the tail is not the popped head when count>1.
  - Merge effect: be := be_old | be_new; lanes with be_new=1 take the new data; count is unchanged.
  - A merge is still subject to in_ready (full ⇒ no accept).
- Not defined: every accepted store allocates a new entry.

Decomposition:
- Shared def header:
  - store op constants: STORE_SW=2'b00, STORE_SH=2'b01, STORE_SB=2'b10
  - STORE_RSV=2'b11
  - byte-enable constants BE_WORD=4'b1111, BE_LO=4'b0011, BE_HI=4'b1100
- Sub-module store_lane_pack (combinational): op, addr[1:0], wdata → data, be, misalign.

Test Plan:
- Empty buffer, SB addr=0x1003 wdata=0x000000A5, out_ready=0 → next cycle out_valid=1, out_addr=0x1000, out_data=0xA5000000, out_be=4'b1000, count=1.
- SH addr=0x2002 wdata=0x1234BEEF → out_data=0xBEEF0000, be=4'b1100. SH addr=0x2001 → not enqueued, align_err high for 1 cycle, count unchanged.
- out_ready=0, push 4 SWs (0x10,0x14,0x18,0x1C) → count=4, in_ready=0, fifth request stalls. out_ready=1 → pops in order; simultaneous push and pop keeps count constant; pointers wrap correctly.
- Reset asserted with count=3 → next cycle count=0, out_valid=0, in_ready=1, align_err=0. The following SW is the only entry drained.
- STORE_MERGE_EN, out_ready=0:
  - SB 0x3000 data 0x11, then SB 0x3001 data 0x22 → count=1, be=4'b0011, out_data=0x00002211.
  - Without the macro → count=2.
